mio_mem_responder: RTL and testbench

Memory/IO responder on the far side of the multi-cycle CPU's memory port. It accepts requests carrying address, store data, direction and RAMCtrl access size. It performs the access against an internal word-organised RAM or a small IO register window after a programmable wait, then returns load data on `data2CPU` and raises `MIO_ready`. It sits between the CPU datapath (`M_addr`, `data_out`, `RAMCtrl`) and the board-level switches and LEDs.

---
 rtl/mio_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_mio_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mio_mem_responder.sv
// Memory/IO responder: word RAM plus a switch/LED register window,
// answering one sized load/store per mem_req after a fixed wait.
module mio_mem_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [3:0]  IO_NIBBLE   = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_w,
  input  logic [2:0]  RAMCtrl,
  input  logic [31:0] M_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data2CPU,
  output logic        MIO_ready,
  output logic        mem_err,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] led_q, led_d;

  logic [31:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] idx;
  logic        is_byte, is_half, sext;
  logic        misal, is_io, io_hit, mem_we;
  logic [31:0] ram_w, raw_w, lane_w, ld_val, wr_w;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign idx     = addr_q[ADDR_W+1:2];
  assign is_byte = (ctrl_q[1:0] == 2'b10);
  assign is_half = (ctrl_q[1:0] == 2'b01);
  assign sext    = !ctrl_q[2];
  assign is_io   = (addr_q[31:28] == IO_NIBBLE);
  assign io_hit  = is_io && (addr_q[27:0] == 28'd0);
  assign ram_w   = mem[idx];

  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      is_byte: misal = 1'b0;
      is_half: misal = addr_q[0];
      default: misal = (addr_q[1:0] != 2'b00);
    endcase
  end

  // IO data passes through the same lane extraction as RAM data
  always_comb begin
    raw_w  = is_io ? (io_hit ? {16'b0, sw_in} : 32'd0) : ram_w;
    lane_w = raw_w >> {addr_q[1:0], 3'b000};
    byte_v = lane_w[7:0];
    half_v = addr_q[1] ? raw_w[31:16] : raw_w[15:0];
    ld_val = raw_w;
    unique case (1'b1)
      is_byte: ld_val = {{24{sext & byte_v[7]}}, byte_v};
      is_half: ld_val = {{16{sext & half_v[15]}}, half_v};
      default: ld_val = raw_w;
    endcase
  end

  always_comb begin
    wr_w = ram_w;
    unique case (1'b1)
      is_byte: wr_w[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      is_half: wr_w[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_w = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    led_d   = led_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          addr_d  = M_addr;
          wdata_d = data_out;
          ctrl_d  = RAMCtrl;
          we_d    = mem_w;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          err_d   = misal;
          if (misal)
            rdata_d = 32'd0;
          else if (!we_q)
            rdata_d = ld_val;
          if (we_q && !misal) begin
            if (!is_io)
              mem_we = 1'b1;
            else if (io_hit)
              led_d = wdata_q[15:0];
          end
        end
      end
      S_DONE: begin
        if (!mem_req) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ctrl_q  <= 3'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      led_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  // RAM is never cleared; reset drops a pending write via state_q
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[idx] <= wr_w;
  end

  assign MIO_ready = (state_q != S_BUSY);
  assign data2CPU  = rdata_q;
  assign mem_err   = err_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_mio_mem_responder.sv
// Directed bench for mio_mem_responder: sized RAM access,
// alignment, wrap, IO window, latency and async reset.
module tb_mio_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_w;
  logic [2:0]  RAMCtrl;
  logic [31:0] M_addr;
  logic [31:0] data_out;
  logic [31:0] data2CPU;
  logic        MIO_ready;
  logic        mem_err;
  logic [15:0] sw_in;
  logic [15:0] led_out;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [2:0] C_W  = 3'b000;
  localparam logic [2:0] C_HS = 3'b001;
  localparam logic [2:0] C_BS = 3'b010;
  localparam logic [2:0] C_BU = 3'b110;

  mio_mem_responder #(
    .ADDR_W(10),
    .WAIT_CYCLES(2),
    .IO_NIBBLE(4'hF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_w(mem_w),
    .RAMCtrl(RAMCtrl),
    .M_addr(M_addr),
    .data_out(data_out),
    .data2CPU(data2CPU),
    .MIO_ready(MIO_ready),
    .mem_err(mem_err),
    .sw_in(sw_in),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; M_addr/data_out are scrambled after
  // the request edge to show the request was latched.
  task automatic access(input logic w,
                        input logic [2:0] c,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd,
                        output logic er,
                        output int low);
    bit done;
    @(negedge clk);
    mem_req  = 1'b1;
    mem_w    = w;
    RAMCtrl  = c;
    M_addr   = a;
    data_out = d;
    low  = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      M_addr   = 32'h5A5A5A5A;
      data_out = ~d;
      if (!MIO_ready) low++;
      else done = 1;
    end
    if (!done) chk("timeout", {31'b0, MIO_ready}, 32'd1);
    rd = data2CPU;
    er = mem_err;
    @(negedge clk);
    mem_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          low;

  initial begin
    reset    = 1'b1;
    mem_req  = 1'b0;
    mem_w    = 1'b0;
    RAMCtrl  = 3'b000;
    M_addr   = 32'd0;
    data_out = 32'd0;
    sw_in    = 16'h0000;
    #12;
    chk("rst_ready", {31'b0, MIO_ready}, 32'd1);
    chk("rst_data", data2CPU, 32'd0);
    chk("rst_err", {31'b0, mem_err}, 32'd0);
    chk("rst_led", {16'b0, led_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    access(1, C_W, 32'h10, 32'hDEADBEEF, rd, er, low);
    chk("st_low", low, 32'd3);
    access(0, C_W, 32'h10, 32'h0, rd, er, low);
    chk("ld_low", low, 32'd3);
    chk("ld_word", rd, 32'hDEADBEEF);
    chk("ld_err", {31'b0, er}, 32'd0);

    access(1, C_W, 32'h20, 32'h80FF7F01, rd, er, low);
    access(0, C_BS, 32'h23, 32'h0, rd, er, low);
    chk("lb_s", rd, 32'hFFFFFF80);
    access(0, C_BU, 32'h23, 32'h0, rd, er, low);
    chk("lb_u", rd, 32'h00000080);
    access(0, C_HS, 32'h20, 32'h0, rd, er, low);
    chk("lh_lo", rd, 32'h00007F01);
    access(0, C_HS, 32'h22, 32'h0, rd, er, low);
    chk("lh_hi", rd, 32'hFFFF80FF);
    access(0, 3'b101, 32'h22, 32'h0, rd, er, low);
    chk("lhu_hi", rd, 32'h000080FF);

    access(1, C_W, 32'h20, 32'h11223344, rd, er, low);
    access(1, C_BS, 32'h21, 32'h000000AA, rd, er, low);
    access(0, C_W, 32'h20, 32'h0, rd, er, low);
    chk("sb_merge", rd, 32'h1122AA44);
    access(1, C_HS, 32'h22, 32'h0000BEEF, rd, er, low);
    access(0, C_W, 32'h20, 32'h0, rd, er, low);
    chk("sh_merge", rd, 32'hBEEFAA44);

    access(0, C_W, 32'h12, 32'h0, rd, er, low);
    chk("mis_ld_err", {31'b0, er}, 32'd1);
    chk("mis_ld_data", rd, 32'd0);
    chk("err_clr", {31'b0, mem_err}, 32'd0);
    access(1, C_W, 32'h12, 32'hCAFEF00D, rd, er, low);
    chk("mis_st_err", {31'b0, er}, 32'd1);
    access(0, C_W, 32'h10, 32'h0, rd, er, low);
    chk("mis_st_keep", rd, 32'hDEADBEEF);
    access(0, C_HS, 32'h11, 32'h0, rd, er, low);
    chk("mis_half", {31'b0, er}, 32'd1);

    access(1, C_W, 32'h1000, 32'h12345678, rd, er, low);
    access(0, C_W, 32'h0, 32'h0, rd, er, low);
    chk("wrap", rd, 32'h12345678);

    access(1, C_W, 32'hF0000000, 32'h0000A5A5, rd, er, low);
    chk("io_led", {16'b0, led_out}, 32'h0000A5A5);
    sw_in = 16'h8001;
    access(0, C_W, 32'hF0000000, 32'h0, rd, er, low);
    chk("io_sw", rd, 32'h00008001);
    access(0, C_HS, 32'hF0000000, 32'h0, rd, er, low);
    chk("io_sw_h", rd, 32'hFFFF8001);
    access(1, C_W, 32'hF0000004, 32'h0000FFFF, rd, er, low);
    chk("io_other", {16'b0, led_out}, 32'h0000A5A5);
    access(0, C_W, 32'hF0000004, 32'h0, rd, er, low);
    chk("io_other_ld", rd, 32'd0);

    // reset in the middle of a pending store
    @(negedge clk);
    mem_req  = 1'b1;
    mem_w    = 1'b1;
    RAMCtrl  = C_W;
    M_addr   = 32'h10;
    data_out = 32'h0BADF00D;
    @(posedge clk);
    #1;
    chk("busy", {31'b0, MIO_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_ready", {31'b0, MIO_ready}, 32'd1);
    chk("arst_data", data2CPU, 32'd0);
    chk("arst_led", {16'b0, led_out}, 32'd0);
    @(negedge clk);
    mem_req = 1'b0;
    reset   = 1'b0;
    access(0, C_W, 32'h10, 32'h0, rd, er, low);
    chk("arst_nowr", rd, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
